// File: rtl/rr_packet_arbiter_if.sv
// Handshake bundle between one crossbar master port and its packet arbiter.
// The arbiter binds to the slave modport; the request/beat source binds to master.
interface rr_packet_arbiter_if #(
    parameter int unsigned S_DATA_COUNT = 5,
    parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT)
);
    logic [S_DATA_COUNT-1:0] req_i;
    logic                    beat_accept_i;
    logic                    beat_last_i;
    logic [S_DATA_COUNT-1:0] grant_o;
    logic [T_ID___WIDTH-1:0] m_id_o;
    logic                    busy_o;
    logic                    forced_release_o;

    modport master (
        output req_i, beat_accept_i, beat_last_i,
        input  grant_o, m_id_o, busy_o, forced_release_o
    );

    modport slave (
        input  req_i, beat_accept_i, beat_last_i,
        output grant_o, m_id_o, busy_o, forced_release_o
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Packet-locking round-robin arbiter: grant held until last, priority rotates past the winner.
// Define RR_ARB_MAX_BEATS_EN to force-release a grant after MAX_BEATS accepted beats.
module rr_packet_arbiter #(
    parameter int unsigned S_DATA_COUNT   = 5,
    parameter int unsigned T_ID___WIDTH   = $clog2(S_DATA_COUNT),
    parameter int unsigned MAX_BEATS      = 16,
    parameter int unsigned BEAT_CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input logic                clk,
    input logic                rst,
    rr_packet_arbiter_if.slave arb_if
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state, w_state;
    logic [T_ID___WIDTH-1:0] r_ptr, w_ptr;
    logic [T_ID___WIDTH-1:0] r_winner, w_winner;
    logic [S_DATA_COUNT-1:0] r_grant, w_grant;
    logic                    r_busy;
    logic                    r_forced, w_forced;

    logic [T_ID___WIDTH-1:0] w_ptr_adv;
    logic [T_ID___WIDTH-1:0] w_base;
    logic [T_ID___WIDTH-1:0] w_pick;
    logic [S_DATA_COUNT-1:0] w_pick_oh;
    logic                    w_found;
    logic                    w_limit;
    logic                    w_release;
    int unsigned             w_idx;

`ifdef RR_ARB_MAX_BEATS_EN
    logic [BEAT_CNT_WIDTH-1:0] r_cnt, w_cnt, w_cnt_inc;
`endif

    always_comb begin
        w_ptr_adv = (r_winner == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : r_winner + 1'b1;
`ifdef RR_ARB_MAX_BEATS_EN
        w_cnt_inc = r_cnt + 1'b1;
        w_limit   = arb_if.beat_accept_i & ~arb_if.beat_last_i
                    & (w_cnt_inc == BEAT_CNT_WIDTH'(MAX_BEATS));
`else
        w_limit   = 1'b0;
`endif
        w_release = (r_state == ST_LOCKED) & arb_if.beat_accept_i
                    & (arb_if.beat_last_i | w_limit);
        // On release the search already starts past the finishing slave
        w_base    = w_release ? w_ptr_adv : r_ptr;

        w_found   = 1'b0;
        w_pick    = '0;
        w_pick_oh = '0;
        w_idx     = 0;
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
            w_idx = (32'(w_base) + k) % S_DATA_COUNT;
            if (!w_found && arb_if.req_i[w_idx[T_ID___WIDTH-1:0]]) begin
                w_found   = 1'b1;
                w_pick    = w_idx[T_ID___WIDTH-1:0];
                w_pick_oh = '0;
                w_pick_oh[w_idx[T_ID___WIDTH-1:0]] = 1'b1;
            end
        end

        w_state  = r_state;
        w_ptr    = r_ptr;
        w_winner = r_winner;
        w_grant  = r_grant;
        w_forced = 1'b0;
`ifdef RR_ARB_MAX_BEATS_EN
        w_cnt    = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state  = ST_LOCKED;
                    w_winner = w_pick;
                    w_grant  = w_pick_oh;
`ifdef RR_ARB_MAX_BEATS_EN
                    w_cnt    = '0;
`endif
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_ptr    = w_ptr_adv;
                    w_forced = w_limit;
`ifdef RR_ARB_MAX_BEATS_EN
                    w_cnt    = '0;
`endif
                    if (w_found) begin
                        w_winner = w_pick;
                        w_grant  = w_pick_oh;
                    end else begin
                        w_state = ST_IDLE;
                        w_grant = '0;
                    end
                end
`ifdef RR_ARB_MAX_BEATS_EN
                else if (arb_if.beat_accept_i) begin
                    w_cnt = w_cnt_inc;
                end
`endif
            end
            default: begin
                w_state = ST_IDLE;
                w_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_forced <= 1'b0;
`ifdef RR_ARB_MAX_BEATS_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_winner <= w_winner;
            r_grant  <= w_grant;
            r_busy   <= (w_state == ST_LOCKED);
            r_forced <= w_forced;
`ifdef RR_ARB_MAX_BEATS_EN
            r_cnt    <= w_cnt;
`endif
        end
    end

    assign arb_if.grant_o = r_grant;
    assign arb_if.m_id_o  = r_winner;
    assign arb_if.busy_o  = r_busy;
`ifdef RR_ARB_MAX_BEATS_EN
    assign arb_if.forced_release_o = r_forced;
`else
    // Limit logic absent: always 0 for any legal MAX_BEATS (>=1)
    assign arb_if.forced_release_o = r_forced & (MAX_BEATS == 0) & (BEAT_CNT_WIDTH == 0);
`endif
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomized bench for rr_packet_arbiter against a queue-free arithmetic reference model,
// plus directed scenarios with literal expectations.
module tb_rr_packet_arbiter;
    localparam int unsigned S  = 5;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_packet_arbiter_if #(.S_DATA_COUNT(S)) u_if ();

    rr_packet_arbiter #(
        .S_DATA_COUNT(S),
        .MAX_BEATS   (MB)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .arb_if(u_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: who holds the grant, where priority starts, beats so far
    int m_ptr, m_win, m_cnt;
    bit m_busy, m_forced;

    function automatic int pick(input logic [S-1:0] req, input int from);
        for (int k = 0; k < S; k++)
            if (req[(from + k) % S]) return (from + k) % S;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit rel;
        if (rst) begin
            m_ptr = 0; m_win = 0; m_cnt = 0; m_busy = 0; m_forced = 0;
        end else begin
            m_forced = 0;
            if (!m_busy) begin
                if (u_if.req_i != 0) begin
                    m_win  = pick(u_if.req_i, m_ptr);
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end else if (u_if.beat_accept_i) begin
                m_cnt++;
                rel = u_if.beat_last_i;
`ifdef RR_ARB_MAX_BEATS_EN
                if (!u_if.beat_last_i && m_cnt == MB) begin
                    rel = 1;
                    m_forced = 1;
                end
`endif
                if (rel) begin
                    m_ptr = (m_win + 1) % S;
                    m_cnt = 0;
                    if (u_if.req_i != 0) m_win = pick(u_if.req_i, m_ptr);
                    else m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("grant_o",          32'(u_if.grant_o),          m_busy ? (32'd1 << m_win) : 32'd0);
            chk("m_id_o",           32'(u_if.m_id_o),           32'(m_win));
            chk("busy_o",           32'(u_if.busy_o),           32'(m_busy));
            chk("forced_release_o", 32'(u_if.forced_release_o), 32'(m_forced));
        end
    end

    task automatic drive(input logic [S-1:0] req, input logic acc, input logic last);
        u_if.req_i         = req;
        u_if.beat_accept_i = acc;
        u_if.beat_last_i   = last;
        @(negedge clk);
    endtask

    initial begin
        u_if.req_i = '0;
        u_if.beat_accept_i = 1'b0;
        u_if.beat_last_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset grant",  32'(u_if.grant_o), 32'h0);
        chk("reset m_id",   32'(u_if.m_id_o), 32'h0);
        chk("reset busy",   32'(u_if.busy_o), 32'h0);
        chk("reset forced", 32'(u_if.forced_release_o), 32'h0);

        // First grant from ptr 0
        drive(5'b10100, 1'b0, 1'b0);
        chk("first grant", 32'(u_if.grant_o), 32'b00100);
        chk("first m_id",  32'(u_if.m_id_o), 32'd2);
        chk("first busy",  32'(u_if.busy_o), 32'd1);

        // Zero-bubble rotation 2 -> 3 -> 4 -> 0
        drive(5'b11111, 1'b1, 1'b0);
        drive(5'b11111, 1'b1, 1'b0);
        drive(5'b11111, 1'b1, 1'b1);
        chk("handover to 3", 32'(u_if.grant_o), 32'b01000);
        chk("busy on handover", 32'(u_if.busy_o), 32'd1);
        drive(5'b11111, 1'b1, 1'b1);
        chk("handover to 4", 32'(u_if.grant_o), 32'b10000);
        drive(5'b11111, 1'b1, 1'b1);
        chk("wrap to 0", 32'(u_if.grant_o), 32'b00001);
        chk("wrap m_id", 32'(u_if.m_id_o), 32'd0);

        // Grant to 1, then its request drops mid-packet
        drive(5'b00010, 1'b1, 1'b1);
        chk("grant 1", 32'(u_if.grant_o), 32'b00010);
        drive(5'b00000, 1'b1, 1'b0);
        chk("hold after req drop", 32'(u_if.grant_o), 32'b00010);
        drive(5'b00000, 1'b1, 1'b1);
        chk("idle after last", 32'(u_if.grant_o), 32'h0);
        chk("idle busy", 32'(u_if.busy_o), 32'd0);
        chk("idle m_id holds", 32'(u_if.m_id_o), 32'd1);

        // Lone requester 4 re-granted back-to-back; ptr wraps to 0
        drive(5'b10000, 1'b0, 1'b0);
        chk("lone grant", 32'(u_if.grant_o), 32'b10000);
        drive(5'b10000, 1'b1, 1'b1);
        chk("lone regrant", 32'(u_if.grant_o), 32'b10000);
        drive(5'b00000, 1'b1, 1'b1);
        chk("lone idle", 32'(u_if.busy_o), 32'd0);
        drive(5'b00011, 1'b0, 1'b0);
        chk("ptr wrapped to 0", 32'(u_if.grant_o), 32'b00001);

        // Beat limit on slave 0 with req 00011 held
        drive(5'b00011, 1'b1, 1'b0);
        drive(5'b00011, 1'b1, 1'b0);
        drive(5'b00011, 1'b1, 1'b0);
        chk("no pulse before limit", 32'(u_if.forced_release_o), 32'd0);
        drive(5'b00011, 1'b1, 1'b0);
`ifdef RR_ARB_MAX_BEATS_EN
        chk("forced pulse", 32'(u_if.forced_release_o), 32'd1);
        chk("forced handover", 32'(u_if.grant_o), 32'b00010);
`else
        chk("no limit pulse", 32'(u_if.forced_release_o), 32'd0);
        chk("no limit hold", 32'(u_if.grant_o), 32'b00001);
`endif
        drive(5'b00011, 1'b1, 1'b0);
        chk("pulse one cycle", 32'(u_if.forced_release_o), 32'd0);
        drive(5'b00011, 1'b1, 1'b0);
        drive(5'b00011, 1'b1, 1'b1);
        drive(5'b00000, 1'b1, 1'b1);
        chk("limit section idle", 32'(u_if.busy_o), 32'd0);

        // Async reset between edges
        drive(5'b00100, 1'b0, 1'b0);
        chk("pre-reset grant", 32'(u_if.grant_o), 32'b00100);
        #2 rst = 1'b1;
        #1;
        chk("async reset grant", 32'(u_if.grant_o), 32'h0);
        chk("async reset busy",  32'(u_if.busy_o), 32'd0);
        u_if.req_i = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        drive(5'b01000, 1'b0, 1'b0);
        chk("post-reset m_id", 32'(u_if.m_id_o), 32'd3);
        chk("post-reset grant", 32'(u_if.grant_o), 32'b01000);

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                drive('0, 1'b0, 1'b0);
                rst = 1'b0;
            end else begin
                drive(($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            end
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
